// File: rtl/alu_lockstep_ctrl.sv
// alu_lockstep_ctrl
// Sequencer for a dual-lane 4-bit ALU lockstep checker. Takes one operation
// at a time over a valid/ready request channel and drives identical operands
// and select to both external ALU lanes. After SETTLE cycles it compares the
// lanes, counts faults, and returns lane 0's result over a valid/ready
// response channel.
//
// Optional feature macro: ALU_LOCKSTEP_RETRY_EN
//   When defined, a first mismatch triggers one re-compare after another
//   SETTLE cycles. A match on that re-compare counts as a recovered retry.
//   When undefined, the first mismatch is final and retry_cnt is tied to 0.
//
// Parameters
//   SETTLE : lane settle cycles before each compare (1..15)
//   CNT_W  : width of the fault and retry counters
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake
//   req_a, req_b, req_op        operands and op (00 add, 01 sub, 10 and, 11 or)
//   lane_a, lane_b, lane_sel    registered operands/select to both lanes
//   lane0_out/carry             lane 0 result and carry-out
//   lane1_out/carry             lane 1 result and carry-out
//   rsp_valid/rsp_ready         response handshake
//   rsp_result, rsp_carry       lane 0 result and carry captured at compare
//   rsp_fault                   final lane disagreement for this response
//   fault_sticky                set on any fault, held until clr_fault
//   fault_cnt, retry_cnt        saturating event counters
//   clr_fault                   synchronous clear of sticky and counters
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | ready for a request, lanes hold the last operation
// WAIT       | lanes settling, counting down to the first compare
// RETRY_WAIT | first compare mismatched, settling for the re-compare
// RESP       | response presented, waiting for rsp_ready

module alu_lockstep_ctrl #(
   parameter int SETTLE = 1,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_a,
   input  logic [3:0]       req_b,
   input  logic [1:0]       req_op,
   output logic [3:0]       lane_a,
   output logic [3:0]       lane_b,
   output logic [1:0]       lane_sel,
   input  logic [3:0]       lane0_out,
   input  logic [3:0]       lane1_out,
   input  logic             lane0_carry,
   input  logic             lane1_carry,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [3:0]       rsp_result,
   output logic             rsp_carry,
   output logic             rsp_fault,
   output logic             fault_sticky,
   output logic [CNT_W-1:0] fault_cnt,
   output logic [CNT_W-1:0] retry_cnt,
   input  logic             clr_fault
);

`ifdef ALU_LOCKSTEP_RETRY_EN
   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_WAIT       = 2'd1,
      S_RESP       = 2'd2,
      S_RETRY_WAIT = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;
`endif

   localparam logic [3:0]       SETTLE_L = 4'(SETTLE);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t     state_q;
   state_t     state_d;
   logic       run_q;
   logic [3:0] settle_q;

   logic       accept;
   logic       load_settle;
   logic       capture;
   logic       fault_evt;
   logic       settle_tc;
   logic       lanes_differ;
`ifdef ALU_LOCKSTEP_RETRY_EN
   logic       retry_evt;
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   // Counter value 1 means it reaches zero on this edge: compare now.
   assign settle_tc    = (settle_q == 4'd1);
   assign lanes_differ = ({lane0_carry, lane0_out} != {lane1_carry, lane1_out});

   // run_q keeps req_ready low until the first edge after reset release.
   assign req_ready = run_q && (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);

   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      load_settle = 1'b0;
      capture     = 1'b0;
      fault_evt   = 1'b0;
`ifdef ALU_LOCKSTEP_RETRY_EN
      retry_evt   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid && run_q) begin
               accept      = 1'b1;
               load_settle = 1'b1;
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (settle_tc) begin
               if (lanes_differ) begin
`ifdef ALU_LOCKSTEP_RETRY_EN
                  load_settle = 1'b1;
                  state_d     = S_RETRY_WAIT;
`else
                  capture   = 1'b1;
                  fault_evt = 1'b1;
                  state_d   = S_RESP;
`endif
               end else begin
                  capture = 1'b1;
                  state_d = S_RESP;
               end
            end
         end
`ifdef ALU_LOCKSTEP_RETRY_EN
         S_RETRY_WAIT: begin
            if (settle_tc) begin
               capture = 1'b1;
               if (lanes_differ) begin
                  fault_evt = 1'b1;
               end else begin
                  retry_evt = 1'b1;
               end
               state_d = S_RESP;
            end
         end
`endif
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_q <= 4'd0;
      end else if (load_settle) begin
         settle_q <= SETTLE_L;
      end else if (settle_q != 4'd0) begin
         settle_q <= settle_q - 4'd1;
      end
   end

   // Lane drive only changes on accept, so lanes never move mid-operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_a   <= 4'd0;
         lane_b   <= 4'd0;
         lane_sel <= 2'd0;
      end else if (accept) begin
         lane_a   <= req_a;
         lane_b   <= req_b;
         lane_sel <= req_op;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_result <= 4'd0;
         rsp_carry  <= 1'b0;
         rsp_fault  <= 1'b0;
      end else if (capture) begin
         rsp_result <= lane0_out;
         rsp_carry  <= lane0_carry;
         rsp_fault  <= fault_evt;
      end
   end

   // A fault on the same edge as clr_fault wins: sticky set, count restarts at 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_sticky <= 1'b0;
         fault_cnt    <= '0;
      end else if (fault_evt) begin
         fault_sticky <= 1'b1;
         fault_cnt    <= clr_fault ? CNT_ONE : sat_inc(fault_cnt);
      end else if (clr_fault) begin
         fault_sticky <= 1'b0;
         fault_cnt    <= '0;
      end
   end

`ifdef ALU_LOCKSTEP_RETRY_EN
   logic [CNT_W-1:0] retry_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retry_cnt_q <= '0;
      end else if (retry_evt) begin
         retry_cnt_q <= clr_fault ? CNT_ONE : sat_inc(retry_cnt_q);
      end else if (clr_fault) begin
         retry_cnt_q <= '0;
      end
   end

   assign retry_cnt = retry_cnt_q;
`else
   assign retry_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_lockstep_ctrl.sv
// Randomized self-checking bench for alu_lockstep_ctrl. The two ALU lanes are
// modelled here; lane 1 can be corrupted persistently or only for the first
// compare. Expected responses and counters come from a transaction-level model.
`timescale 1ns/1ps

module tb_alu_lockstep_ctrl;

   localparam int SETTLE = 3;
   localparam int CNT_W  = 2;
   localparam int CMAX   = 3;
`ifdef ALU_LOCKSTEP_RETRY_EN
   localparam bit RETRY = 1'b1;
`else
   localparam bit RETRY = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_a;
   logic [3:0]       req_b;
   logic [1:0]       req_op;
   logic [3:0]       lane_a;
   logic [3:0]       lane_b;
   logic [1:0]       lane_sel;
   logic [3:0]       lane0_out;
   logic [3:0]       lane1_out;
   logic             lane0_carry;
   logic             lane1_carry;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [3:0]       rsp_result;
   logic             rsp_carry;
   logic             rsp_fault;
   logic             fault_sticky;
   logic [CNT_W-1:0] fault_cnt;
   logic [CNT_W-1:0] retry_cnt;
   logic             clr_fault;

   logic [4:0]       flip;
   logic [4:0]       l0;

   int n_vec = 0;
   int n_err = 0;
   int m_sticky = 0;
   int m_fcnt = 0;
   int m_rcnt = 0;

   always #5 clk = ~clk;

   alu_lockstep_ctrl #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_op       (req_op),
      .lane_a       (lane_a),
      .lane_b       (lane_b),
      .lane_sel     (lane_sel),
      .lane0_out    (lane0_out),
      .lane1_out    (lane1_out),
      .lane0_carry  (lane0_carry),
      .lane1_carry  (lane1_carry),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_carry    (rsp_carry),
      .rsp_fault    (rsp_fault),
      .fault_sticky (fault_sticky),
      .fault_cnt    (fault_cnt),
      .retry_cnt    (retry_cnt),
      .clr_fault    (clr_fault)
   );

   // {carry, result}; subtraction carry is the borrow.
   function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] op);
      case (op)
         2'd0:    return {1'b0, a} + {1'b0, b};
         2'd1:    return {1'b0, a} - {1'b0, b};
         2'd2:    return {1'b0, a & b};
         default: return {1'b0, a | b};
      endcase
   endfunction

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   always_comb begin
      l0          = alu_ref(lane_a, lane_b, lane_sel);
      lane0_out   = l0[3:0];
      lane0_carry = l0[4];
      lane1_out   = l0[3:0] ^ flip[3:0];
      lane1_carry = l0[4] ^ flip[4];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0: lanes agree, 1: lane 1 corrupted throughout, 2: corrupted on first compare only
   task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                          input int mode, input int hold, input bit clr_hit,
                          input logic [4:0] fmask);
      int          waited;
      int          lat;
      int          exp_lat;
      bit          exp_fault;
      bit          retry_ok;
      logic [4:0]  exp_r;
      exp_r     = alu_ref(a, b, op);
      exp_fault = (mode == 1) || (mode == 2 && !RETRY);
      retry_ok  = (mode == 2) && RETRY;
      exp_lat   = (RETRY && mode != 0) ? 2 * SETTLE : SETTLE;

      @(negedge clk);
      waited = 0;
      while (!req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_op    = op;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_a     = 4'($urandom);
      req_b     = 4'($urandom);
      req_op    = 2'($urandom);
      if (mode != 0) flip = fmask;
      if (clr_hit && exp_lat == 1) clr_fault = 1'b1;
      chk("lane_a", lane_a, a);
      chk("lane_b", lane_b, b);
      chk("lane_sel", lane_sel, op);

      lat = 0;
      while (lat < 4 * SETTLE + 4) begin
         @(posedge clk);
         lat++;
         #1;
         if (mode == 2 && lat == SETTLE) flip = 5'd0;
         if (clr_hit && lat == exp_lat) clr_fault = 1'b0;
         if (clr_hit && lat == exp_lat - 1) clr_fault = 1'b1;
         if (rsp_valid) break;
         chk("req_ready_busy", req_ready, 0);
         chk("lane_hold", {lane_sel, lane_b, lane_a}, {op, b, a});
      end
      flip      = 5'd0;
      clr_fault = 1'b0;
      chk("rsp_latency", lat, exp_lat);

      m_sticky = exp_fault ? 1 : (clr_hit ? 0 : m_sticky);
      m_fcnt   = exp_fault ? (clr_hit ? 1 : sat(m_fcnt + 1)) : (clr_hit ? 0 : m_fcnt);
      m_rcnt   = retry_ok  ? (clr_hit ? 1 : sat(m_rcnt + 1)) : (clr_hit ? 0 : m_rcnt);

      chk("rsp_result", rsp_result, exp_r[3:0]);
      chk("rsp_carry", rsp_carry, exp_r[4]);
      chk("rsp_fault", rsp_fault, exp_fault);
      chk("fault_sticky", fault_sticky, m_sticky);
      chk("fault_cnt", fault_cnt, m_fcnt);
      chk("retry_cnt", retry_cnt, m_rcnt);

      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", rsp_valid, 1);
         chk("hold_rsp", {rsp_fault, rsp_carry, rsp_result}, {exp_fault, exp_r});
         chk("hold_req_ready", req_ready, 0);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk("rsp_done", rsp_valid, 0);
      chk("req_ready_after", req_ready, 1);
   endtask

   task automatic do_clr();
      @(negedge clk);
      clr_fault = 1'b1;
      @(posedge clk);
      #1;
      clr_fault = 1'b0;
      m_sticky = 0;
      m_fcnt   = 0;
      m_rcnt   = 0;
      chk("clr_sticky", fault_sticky, 0);
      chk("clr_fcnt", fault_cnt, 0);
      chk("clr_rcnt", retry_cnt, 0);
   endtask

   task automatic reset_mid_op();
      @(negedge clk);
      req_valid = 1'b1;
      req_a     = 4'h6;
      req_b     = 4'h2;
      req_op    = 2'd1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      m_sticky = 0;
      m_fcnt   = 0;
      m_rcnt   = 0;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_lanes", {lane_sel, lane_b, lane_a}, 0);
      chk("rst_rsp", {rsp_fault, rsp_carry, rsp_result}, 0);
      chk("rst_sticky", fault_sticky, 0);
      chk("rst_fcnt", fault_cnt, 0);
      chk("rst_rcnt", retry_cnt, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < SETTLE + 4; i++) begin
         @(posedge clk);
         #1;
         chk("post_rst_no_rsp", rsp_valid, 0);
         if (i == 0) chk("post_rst_ready", req_ready, 1);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_a     = 4'd0;
      req_b     = 4'd0;
      req_op    = 2'd0;
      rsp_ready = 1'b0;
      clr_fault = 1'b0;
      flip      = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_req_ready", req_ready, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_lanes", {lane_sel, lane_b, lane_a}, 0);
      chk("reset_rsp", {rsp_fault, rsp_carry, rsp_result}, 0);
      chk("reset_cnts", {fault_sticky, fault_cnt, retry_cnt}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("release_req_ready", req_ready, 1);

      run_txn(4'h7, 4'h5, 2'd0, 0, 0, 1'b0, 5'd0);
      run_txn(4'h3, 4'h5, 2'd1, 0, 0, 1'b0, 5'd0);
      run_txn(4'hC, 4'hA, 2'd2, 0, 0, 1'b0, 5'd0);
      run_txn(4'h3, 4'h4, 2'd3, 1, 0, 1'b0, 5'h01);
      run_txn(4'h9, 4'h9, 2'd0, 2, 0, 1'b0, 5'h01);
      run_txn(4'hF, 4'h1, 2'd0, 0, 5, 1'b0, 5'd0);
      for (int i = 0; i < 5; i++) run_txn(4'(i), 4'hA, 2'd3, 1, 1, 1'b0, 5'h10);
      do_clr();
      run_txn(4'h1, 4'h2, 2'd0, 1, 0, 1'b1, 5'h02);
      do_clr();

      for (int i = 0; i < 40; i++) begin
         int r;
         int mode;
         r    = int'($urandom_range(0, 5));
         mode = (r < 4) ? 0 : r - 3;
         run_txn(4'($urandom), 4'($urandom), 2'($urandom), mode,
                 int'($urandom_range(0, 3)), 1'b0, 5'($urandom_range(1, 31)));
         if ($urandom_range(0, 7) == 0) do_clr();
      end

      run_txn(4'h8, 4'h8, 2'd0, 1, 0, 1'b0, 5'h04);
      reset_mid_op();
      run_txn(4'hE, 4'h3, 2'd1, 0, 0, 1'b0, 5'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
